// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared core definitions: load-op encoding and datapath widths
package cpu_defs;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LW      = 3'd1,
    LB      = 3'd2,
    LBU     = 3'd3,
    LH      = 3'd4,
    LHU     = 3'd5,
    LWL     = 3'd6,
    LWR     = 3'd7
  } ld_op_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - combinational load-data extraction, extension and LWL/LWR merge
module load_align
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [2:0]            ld_op,
  input  logic [1:0]            byte_off,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [DATA_WIDTH-1:0] rt_val,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halves ignore off[0]: misaligned halfword loads are trapped before WB.
  assign byte_lane = ld_data[{byte_off, 3'b000} +: 8];
  assign half_lane = byte_off[1] ? ld_data[31:16] : ld_data[15:0];

  always_comb begin
    result = alu_result;
    case (ld_op_t'(ld_op))
      LW:  result = ld_data;
      LB:  result = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      LBU: result = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      LH:  result = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      LHU: result = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      LWL: begin
        case (byte_off)
          2'd0:    result = {ld_data[7:0],  rt_val[23:0]};
          2'd1:    result = {ld_data[15:0], rt_val[15:0]};
          2'd2:    result = {ld_data[23:0], rt_val[7:0]};
          default: result = ld_data;
        endcase
      end
      LWR: begin
        case (byte_off)
          2'd0:    result = ld_data;
          2'd1:    result = {rt_val[31:24], ld_data[31:8]};
          2'd2:    result = {rt_val[31:16], ld_data[31:16]};
          default: result = {rt_val[31:8],  ld_data[31:24]};
        endcase
      end
      default: result = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage; WB_DEBUG_TRACE_EN adds reference-trace debug ports
module wb_stage
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  wb_allowin,
  input  logic [31:0]           mem_pc,
  input  logic                  mem_rf_we,
  input  logic [ADDR_WIDTH-1:0] mem_dest,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [2:0]            mem_ld_op,
  input  logic [1:0]            mem_byte_off,
  input  logic [DATA_WIDTH-1:0] mem_ld_data,
  input  logic [DATA_WIDTH-1:0] mem_rt_val,
  input  logic                  flush,
  input  logic                  ext_stall,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_dest,
`ifdef WB_DEBUG_TRACE_EN
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [ADDR_WIDTH-1:0] debug_wb_rf_wnum,
  output logic [DATA_WIDTH-1:0] debug_wb_rf_wdata,
`endif
  output logic [31:0]           retire_cnt
);

  logic                  wb_valid_r;
  logic                  wb_rf_we_r;
  logic [ADDR_WIDTH-1:0] wb_dest_r;
  logic [DATA_WIDTH-1:0] wb_result_r;
  logic [31:0]           retire_cnt_r;
  logic [DATA_WIDTH-1:0] ld_result;
  logic                  wb_ready_go;
  logic                  transfer;
  logic                  retire;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .ld_op      (mem_ld_op),
    .byte_off   (mem_byte_off),
    .ld_data    (mem_ld_data),
    .rt_val     (mem_rt_val),
    .alu_result (mem_alu_result),
    .result     (ld_result)
  );

  assign wb_ready_go = ~ext_stall;
  assign wb_allowin  = ~wb_valid_r | wb_ready_go;
  assign transfer    = mem_valid & wb_allowin;
  assign retire      = wb_valid_r & wb_ready_go & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r   <= 1'b0;
      wb_rf_we_r   <= 1'b0;
      wb_dest_r    <= '0;
      wb_result_r  <= '0;
      retire_cnt_r <= '0;
    end else begin
      // Flush wins over both a pending transfer and a stalled holder.
      if (flush)
        wb_valid_r <= 1'b0;
      else if (wb_allowin)
        wb_valid_r <= mem_valid;
      if (transfer) begin
        wb_rf_we_r  <= mem_rf_we;
        wb_dest_r   <= mem_dest;
        wb_result_r <= ld_result;
      end
      if (retire)
        retire_cnt_r <= retire_cnt_r + 32'd1;
    end
  end

  assign rf_wen     = wb_valid_r & wb_rf_we_r & wb_ready_go & (wb_dest_r != '0);
  assign rf_waddr   = wb_dest_r;
  assign rf_wdata   = wb_result_r;
  assign wb_valid   = wb_valid_r;
  assign wb_dest    = (wb_valid_r & wb_rf_we_r) ? wb_dest_r : '0;
  assign retire_cnt = retire_cnt_r;

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] wb_pc_r;

  always_ff @(posedge clk) begin
    if (rst)
      wb_pc_r <= '0;
    else if (transfer)
      wb_pc_r <= mem_pc;
  end

  assign debug_wb_pc       = wb_pc_r;
  assign debug_wb_rf_wen   = {4{rf_wen}};
  assign debug_wb_rf_wnum  = wb_dest_r;
  assign debug_wb_rf_wdata = wb_result_r;
`else
  logic unused_pc;
  assign unused_pc = ^mem_pc;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a behavioural WB model
module tb_wb_stage;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        wb_allowin;
  logic [31:0] mem_pc = '0;
  logic        mem_rf_we = 1'b0;
  logic [4:0]  mem_dest = '0;
  logic [31:0] mem_alu_result = '0;
  logic [2:0]  mem_ld_op = '0;
  logic [1:0]  mem_byte_off = '0;
  logic [31:0] mem_ld_data = '0;
  logic [31:0] mem_rt_val = '0;
  logic        flush = 1'b0;
  logic        ext_stall = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] retire_cnt;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  int checks = 0;
  int passed = 0;

  logic        m_valid = 1'b0;
  logic        m_we = 1'b0;
  logic [4:0]  m_dest = '0;
  logic [31:0] m_res = '0;
  logic [31:0] m_cnt = '0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .wb_allowin     (wb_allowin),
    .mem_pc         (mem_pc),
    .mem_rf_we      (mem_rf_we),
    .mem_dest       (mem_dest),
    .mem_alu_result (mem_alu_result),
    .mem_ld_op      (mem_ld_op),
    .mem_byte_off   (mem_byte_off),
    .mem_ld_data    (mem_ld_data),
    .mem_rt_val     (mem_rt_val),
    .flush          (flush),
    .ext_stall      (ext_stall),
    .rf_wen         (rf_wen),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
`ifdef WB_DEBUG_TRACE_EN
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
`endif
    .retire_cnt     (retire_cnt)
  );

  // Load result from the ISA rules: shifts and masks on whole words.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] d, input logic [31:0] rt,
                                           input logic [31:0] alu);
    logic [31:0] b;
    logic [31:0] h;
    int sh;
    b = (d >> (8 * int'(off))) & 32'hFF;
    h = off[1] ? (d >> 16) : (d & 32'hFFFF);
    case (op)
      3'd1: return d;
      3'd2: return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd3: return b;
      3'd4: return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5: return h;
      3'd6: begin
        sh = 8 * (int'(off) + 1);
        if (sh == 32) return d;
        return (d << (32 - sh)) | (rt & (32'hFFFF_FFFF >> sh));
      end
      3'd7: begin
        sh = 8 * int'(off);
        if (sh == 0) return d;
        return (d >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
      end
      default: return alu;
    endcase
  endfunction

  function automatic logic exp_wen();
    return m_valid && m_we && !ext_stall && (m_dest != 5'd0);
  endfunction

  // Advance the model with the current inputs, then cross one clock edge.
  task automatic tick();
    logic allow;
    allow = !m_valid || !ext_stall;
    if (rst) begin
      m_valid = 1'b0; m_we = 1'b0; m_dest = '0; m_res = '0; m_cnt = '0;
    end else begin
      if (m_valid && !ext_stall && !flush) m_cnt = m_cnt + 32'd1;
      if (mem_valid && allow) begin
        m_we   = mem_rf_we;
        m_dest = mem_dest;
        m_res  = ref_load(mem_ld_op, mem_byte_off, mem_ld_data, mem_rt_val, mem_alu_result);
      end
      if (flush) m_valid = 1'b0;
      else if (allow) m_valid = mem_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] off, input logic [31:0] d,
                      input logic [31:0] rt, input logic [31:0] alu, input logic we,
                      input logic [4:0] dest);
    mem_valid = 1'b1; mem_ld_op = op; mem_byte_off = off; mem_ld_data = d;
    mem_rt_val = rt; mem_alu_result = alu; mem_rf_we = we; mem_dest = dest;
    mem_pc = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (rf_wen !== 1'b0) $display("FAIL reset_wen got %0b want 0", rf_wen); else passed++;
    checks++; if (rf_waddr !== 5'd0) $display("FAIL reset_waddr got %0d want 0", rf_waddr); else passed++;
    checks++; if (rf_wdata !== 32'd0) $display("FAIL reset_wdata got %h want 0", rf_wdata); else passed++;
    checks++; if (wb_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", wb_valid); else passed++;
    checks++; if (wb_dest !== 5'd0) $display("FAIL reset_dest got %0d want 0", wb_dest); else passed++;
    checks++; if (retire_cnt !== 32'd0) $display("FAIL reset_cnt got %h want 0", retire_cnt); else passed++;
    checks++; if (wb_allowin !== 1'b1) $display("FAIL reset_allowin got %0b want 1", wb_allowin); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  ops [4] = '{3'd2, 3'd3, 3'd6, 3'd7};
    logic [1:0]  offs[4] = '{2'd1, 2'd1, 2'd1, 2'd2};
    logic [31:0] ds  [4] = '{32'h1234_80FF, 32'h1234_80FF, 32'hAABB_CCDD, 32'hAABB_CCDD};
    logic [31:0] rts [4] = '{32'h0, 32'h0, 32'h1122_3344, 32'h1122_3344};
    logic [31:0] exps[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hCCDD_3344, 32'h1122_AABB};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], offs[i], ds[i], rts[i], 32'h5555_5555, 1'b1, 5'd3);
      tick();
      mem_valid = 1'b0;
      #1;
      checks++; if (rf_wen !== 1'b1) $display("FAIL load%0d_wen got %0b want 1", i, rf_wen); else passed++;
      checks++; if (rf_wdata !== exps[i]) $display("FAIL load%0d_data got %h want %h", i, rf_wdata, exps[i]); else passed++;
      checks++; if (rf_wdata !== m_res) $display("FAIL load%0d_model got %h want %h", i, rf_wdata, m_res); else passed++;
      tick();
    end
  endtask

  task automatic test_dest_zero();
    logic [31:0] base;
    base = m_cnt;
    send(LD_NONE, 2'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd0);
    tick();
    mem_valid = 1'b0;
    #1;
    checks++; if (rf_wen !== 1'b0) $display("FAIL dest0_wen got %0b want 0", rf_wen); else passed++;
    tick();
    checks++; if (retire_cnt !== base + 32'd1) $display("FAIL dest0_cnt got %h want %h", retire_cnt, base + 32'd1); else passed++;
    send(LD_NONE, 2'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd5);
    tick();
    mem_valid = 1'b0;
    #1;
    checks++; if (rf_wen !== 1'b1) $display("FAIL dest5_wen got %0b want 1", rf_wen); else passed++;
    checks++; if (rf_waddr !== 5'd5) $display("FAIL dest5_waddr got %0d want 5", rf_waddr); else passed++;
    checks++; if (rf_wdata !== 32'hDEAD_BEEF) $display("FAIL dest5_wdata got %h want deadbeef", rf_wdata); else passed++;
    checks++; if (wb_dest !== 5'd5) $display("FAIL dest5_wbdest got %0d want 5", wb_dest); else passed++;
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] base;
    send(LD_NONE, 2'd0, 32'h0, 32'h0, 32'h1111_1111, 1'b1, 5'd7);
    tick();
    base = m_cnt;
    ext_stall = 1'b1;
    send(LD_NONE, 2'd0, 32'h0, 32'h0, 32'h2222_2222, 1'b1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (wb_allowin !== 1'b0) $display("FAIL stall%0d_allowin got %0b want 0", i, wb_allowin); else passed++;
      checks++; if (rf_wen !== 1'b0) $display("FAIL stall%0d_wen got %0b want 0", i, rf_wen); else passed++;
      tick();
      checks++; if (rf_wdata !== 32'h1111_1111) $display("FAIL stall%0d_hold got %h want 11111111", i, rf_wdata); else passed++;
      checks++; if (retire_cnt !== base) $display("FAIL stall%0d_cnt got %h want %h", i, retire_cnt, base); else passed++;
    end
    ext_stall = 1'b0;
    #1;
    checks++; if (rf_wen !== 1'b1) $display("FAIL unstall_wen got %0b want 1", rf_wen); else passed++;
    checks++; if (rf_waddr !== 5'd7) $display("FAIL unstall_waddr got %0d want 7", rf_waddr); else passed++;
    tick();
    mem_valid = 1'b0;
    checks++; if (retire_cnt !== base + 32'd1) $display("FAIL unstall_cnt got %h want %h", retire_cnt, base + 32'd1); else passed++;
    checks++; if (rf_wdata !== 32'h2222_2222) $display("FAIL unstall_next got %h want 22222222", rf_wdata); else passed++;
  endtask

  task automatic test_flush_stall();
    logic [31:0] base;
    base = m_cnt;
    ext_stall = 1'b1;
    flush = 1'b1;
    send(LD_NONE, 2'd0, 32'h0, 32'h0, 32'h3333_3333, 1'b1, 5'd11);
    #1;
    checks++; if (rf_wen !== 1'b0) $display("FAIL flush_wen got %0b want 0", rf_wen); else passed++;
    tick();
    flush = 1'b0; ext_stall = 1'b0; mem_valid = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", wb_valid); else passed++;
    checks++; if (rf_wen !== 1'b0) $display("FAIL flush_wen2 got %0b want 0", rf_wen); else passed++;
    checks++; if (retire_cnt !== base) $display("FAIL flush_cnt got %h want %h", retire_cnt, base); else passed++;
    tick();
  endtask

  task automatic test_wrap();
    tick();
    force dut.retire_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt_r;
    m_cnt = 32'hFFFF_FFFE;
    send(LD_NONE, 2'd0, 32'h0, 32'h0, 32'h4444_4444, 1'b0, 5'd0);
    tick();
    checks++; if (retire_cnt !== 32'hFFFF_FFFE) $display("FAIL wrap_pre got %h want fffffffe", retire_cnt); else passed++;
    tick();
    checks++; if (retire_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_max got %h want ffffffff", retire_cnt); else passed++;
    tick();
    checks++; if (retire_cnt !== 32'h0) $display("FAIL wrap_zero got %h want 0", retire_cnt); else passed++;
    mem_valid = 1'b0;
    tick();
    checks++; if (retire_cnt !== 32'h1) $display("FAIL wrap_one got %h want 1", retire_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    send(LW, 2'd0, 32'h7777_7777, 32'h0, 32'h0, 1'b1, 5'd13);
    tick();
    ext_stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ext_stall = 1'b0; mem_valid = 1'b0;
    #1;
    checks++; if (rf_wen !== 1'b0) $display("FAIL rstmid_wen got %0b want 0", rf_wen); else passed++;
    checks++; if (rf_waddr !== 5'd0) $display("FAIL rstmid_waddr got %0d want 0", rf_waddr); else passed++;
    checks++; if (rf_wdata !== 32'd0) $display("FAIL rstmid_wdata got %h want 0", rf_wdata); else passed++;
    checks++; if (wb_valid !== 1'b0) $display("FAIL rstmid_valid got %0b want 0", wb_valid); else passed++;
    checks++; if (wb_dest !== 5'd0) $display("FAIL rstmid_dest got %0d want 0", wb_dest); else passed++;
    checks++; if (retire_cnt !== 32'd0) $display("FAIL rstmid_cnt got %h want 0", retire_cnt); else passed++;
  endtask

  task automatic test_random();
    logic [4:0] exp_dest;
    for (int i = 0; i < 400; i++) begin
      send(3'($urandom), 2'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom));
      mem_valid = ($urandom_range(0, 3) != 0);
      ext_stall = ($urandom_range(0, 9) < 3);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      checks++; if (rf_wen !== exp_wen()) $display("FAIL rnd%0d_wen got %0b want %0b", i, rf_wen, exp_wen()); else passed++;
      checks++; if (wb_valid !== m_valid) $display("FAIL rnd%0d_valid got %0b want %0b", i, wb_valid, m_valid); else passed++;
      checks++; if (wb_allowin !== (!m_valid || !ext_stall)) $display("FAIL rnd%0d_allowin got %0b want %0b", i, wb_allowin, !m_valid || !ext_stall); else passed++;
      checks++; if (retire_cnt !== m_cnt) $display("FAIL rnd%0d_cnt got %h want %h", i, retire_cnt, m_cnt); else passed++;
      if (exp_wen()) begin
        checks++; if (rf_waddr !== m_dest) $display("FAIL rnd%0d_waddr got %0d want %0d", i, rf_waddr, m_dest); else passed++;
        checks++; if (rf_wdata !== m_res) $display("FAIL rnd%0d_wdata got %h want %h", i, rf_wdata, m_res); else passed++;
      end
      if (!ext_stall) begin
        exp_dest = (m_valid && m_we) ? m_dest : 5'd0;
        checks++; if (wb_dest !== exp_dest) $display("FAIL rnd%0d_wbdest got %0d want %0d", i, wb_dest, exp_dest); else passed++;
      end
      tick();
    end
    mem_valid = 1'b0; ext_stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_loads();
    test_dest_zero();
    test_stall();
    test_flush_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
